// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, req/ack instruction-memory handshake, instruction register and next-PC logic.
// Optional FETCH_PERF_CNT_EN builds a saturating counter of cycles spent waiting for the memory ack.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          STALL_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    output logic               o_imemReq,
    output logic [31:0]        o_imemAddr,
    input  logic               i_imemAck,
    input  logic [31:0]        i_imemData,
    output logic [31:0]        o_instr,
    output logic [5:0]         o_opcode,
    output logic               o_instrValid,
    output logic [31:0]        o_pc,
    output logic [31:0]        o_pcPlus4,
    input  logic               i_advance,
    input  logic               i_beq,
    input  logic               i_bne,
    input  logic               i_jump,
    input  logic               i_zero,
    output logic [STALL_W-1:0] o_stallCycles
);

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [2:0] {
        S_RESET = 3'b001,
        S_REQ   = 3'b010,
        S_HOLD  = 3'b100
    } fetchState_t;

    fetchState_t state;
    fetchState_t stateNext;

    logic [31:0] pcReg;
    logic [31:0] instrReg;
    logic        validReg;
    logic        loadInstr;
    logic        takeAdvance;
    logic [31:0] pcPlus4;
    logic [31:0] branchTarget;
    logic [31:0] jumpTarget;
    logic [31:0] pcNext;
    logic        branchTaken;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_RESET;
            pcReg    <= RESET_PC_ALIGNED;
            instrReg <= '0;
            validReg <= 1'b0;
        end else begin
            state    <= stateNext;
            validReg <= loadInstr;
            if (loadInstr) begin
                instrReg <= i_imemData;
            end
            if (takeAdvance) begin
                pcReg <= pcNext;
            end
        end
    end

    // Acks are only honoured in S_REQ and advances only in S_HOLD; anything else is dropped.
    always_comb begin
        stateNext   = state;
        loadInstr   = 1'b0;
        takeAdvance = 1'b0;
        case (state)
            S_RESET: stateNext = S_REQ;
            S_REQ: begin
                if (i_imemAck) begin
                    loadInstr = 1'b1;
                    stateNext = S_HOLD;
                end
            end
            S_HOLD: begin
                if (i_advance) begin
                    takeAdvance = 1'b1;
                    stateNext   = S_REQ;
                end
            end
            default: stateNext = S_RESET;
        endcase
    end

    // Jump beats branches; beq and bne together act as "taken if either condition holds".
    always_comb begin
        pcPlus4      = pcReg + 32'd4;
        branchTarget = pcPlus4 + {{14{instrReg[15]}}, instrReg[15:0], 2'b00};
        jumpTarget   = {pcPlus4[31:28], instrReg[25:0], 2'b00};
        branchTaken  = (i_beq & i_zero) | (i_bne & ~i_zero);
        if (i_jump) begin
            pcNext = jumpTarget;
        end else if (branchTaken) begin
            pcNext = branchTarget;
        end else begin
            pcNext = pcPlus4;
        end
        pcNext[1:0] = 2'b00;
    end

    assign o_imemReq    = (state == S_REQ);
    assign o_imemAddr   = pcReg;
    assign o_pc         = pcReg;
    assign o_pcPlus4    = pcPlus4;
    assign o_instr      = instrReg;
    assign o_opcode     = instrReg[31:26];
    assign o_instrValid = validReg;

`ifdef FETCH_PERF_CNT_EN
    localparam logic [STALL_W-1:0] STALL_ONE = 1;

    logic [STALL_W-1:0] stallCnt;

    // Saturates rather than wrapping so a long stall never reads back as a short one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stallCnt <= '0;
        end else if ((state == S_REQ) && !i_imemAck && (stallCnt != '1)) begin
            stallCnt <= stallCnt + STALL_ONE;
        end
    end

    assign o_stallCycles = stallCnt;
`else
    assign o_stallCycles = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized fetch/advance traffic
// checked against an arithmetic next-PC model.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          SW     = 16;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk;
    logic          rstN;
    logic          imemReq;
    logic [31:0]   imemAddr;
    logic          imemAck;
    logic [31:0]   imemData;
    logic [31:0]   instr;
    logic [5:0]    opcode;
    logic          instrValid;
    logic [31:0]   pc;
    logic [31:0]   pcPlus4;
    logic          advance;
    logic          beq;
    logic          bne;
    logic          jump;
    logic          zero;
    logic [SW-1:0] stallCycles;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mPc;
    logic [31:0] mInstr;
    int unsigned mStall;

    instr_fetch #(.RESET_PC(RST_PC), .STALL_W(SW)) dut (
        .i_clk(clk), .i_rst_n(rstN),
        .o_imemReq(imemReq), .o_imemAddr(imemAddr),
        .i_imemAck(imemAck), .i_imemData(imemData),
        .o_instr(instr), .o_opcode(opcode), .o_instrValid(instrValid),
        .o_pc(pc), .o_pcPlus4(pcPlus4),
        .i_advance(advance), .i_beq(beq), .i_bne(bne), .i_jump(jump), .i_zero(zero),
        .o_stallCycles(stallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Next PC from the instruction-set rules, using plain integer arithmetic.
    function automatic logic [31:0] refNextPc(input logic [31:0] curPc, input logic [31:0] word,
                                              input logic b, input logic n, input logic j, input logic z);
        logic [31:0] seq;
        int          off;
        seq = curPc + 32'd4;
        if (j) return (seq & 32'hF000_0000) + (word & 32'h03FF_FFFF) * 32'd4;
        if ((b && z) || (n && !z)) begin
            off = $signed(word[15:0]);
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    function automatic logic [SW-1:0] expStall();
        return PERF ? SW'(mStall) : '0;
    endfunction

    task automatic waitReq();
        int n = 0;
        while (!imemReq && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imemReq) begin
            checks++;
            errors++;
            $display("[TB] FAIL waitReq timeout req=%0b want 1", imemReq);
        end
    endtask

    task automatic fetch(input logic [31:0] data, input int delay);
        waitReq();
        repeat (delay) @(negedge clk);
        mStall += delay;
        imemAck  = 1'b1;
        imemData = data;
        @(negedge clk);
        imemAck  = 1'b0;
        imemData = $urandom;
        mInstr   = data;
    endtask

    task automatic applyStimulus(input logic b, input logic n, input logic j, input logic z);
        beq = b; bne = n; jump = j; zero = z;
        advance = 1'b1;
        mPc = refNextPc(mPc, mInstr, b, n, j, z);
        @(negedge clk);
        advance = 1'b0;
        beq = 1'($urandom); bne = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom);
    endtask

    task automatic test_reset();
        rstN = 1'b0; imemAck = 1'b0; imemData = '0; advance = 1'b0;
        beq = 1'b0; bne = 1'b0; jump = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL rst_req got %b want 0", imemReq); end
        checks++; if (imemAddr !== RST_PC) begin errors++; $display("[TB] FAIL rst_addr got %h want %h", imemAddr, RST_PC); end
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL rst_instr got %h want 0", instr); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("[TB] FAIL rst_valid got %b want 0", instrValid); end
        checks++; if (stallCycles !== '0) begin errors++; $display("[TB] FAIL rst_stall got %0d want 0", stallCycles); end
        rstN = 1'b1;
        @(negedge clk);
        checks++; if (imemReq !== 1'b1) begin errors++; $display("[TB] FAIL rel_req got %b want 1", imemReq); end
        checks++; if (imemAddr !== 32'h100) begin errors++; $display("[TB] FAIL rel_addr got %h want 100", imemAddr); end
        checks++; if (instr !== 32'h0) begin errors++; $display("[TB] FAIL rel_instr got %h want 0", instr); end
        mPc = RST_PC; mInstr = '0; mStall = 0;
    endtask

    task automatic test_sequential();
        fetch(32'h2008_0005, 0);
        checks++; if (instrValid !== 1'b1) begin errors++; $display("[TB] FAIL seq_valid got %b want 1", instrValid); end
        checks++; if (opcode !== 6'h08) begin errors++; $display("[TB] FAIL seq_opcode got %h want 08", opcode); end
        checks++; if (instr !== 32'h2008_0005) begin errors++; $display("[TB] FAIL seq_instr got %h want 20080005", instr); end
        checks++; if (pcPlus4 !== 32'h104) begin errors++; $display("[TB] FAIL seq_pc4 got %h want 104", pcPlus4); end
        @(negedge clk);
        checks++; if (instrValid !== 1'b0) begin errors++; $display("[TB] FAIL seq_pulse got %b want 0", instrValid); end
        checks++; if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL seq_holdreq got %b want 0", imemReq); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (imemReq !== 1'b1) begin errors++; $display("[TB] FAIL seq_nextreq got %b want 1", imemReq); end
        checks++; if (imemAddr !== 32'h104) begin errors++; $display("[TB] FAIL seq_nextaddr got %h want 104", imemAddr); end
    endtask

    task automatic test_branch();
        fetch(32'h0800_0080, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (imemAddr !== 32'h200) begin errors++; $display("[TB] FAIL br_jmp200 got %h want 200", imemAddr); end
        fetch(32'h1000_FFFF, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (imemAddr !== 32'h200) begin errors++; $display("[TB] FAIL beq_taken got %h want 200", imemAddr); end
        fetch(32'h1000_FFFF, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (imemAddr !== 32'h204) begin errors++; $display("[TB] FAIL beq_nottaken got %h want 204", imemAddr); end
        fetch(32'h1400_FFFE, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (imemAddr !== 32'h200) begin errors++; $display("[TB] FAIL bne_taken got %h want 200", imemAddr); end
        fetch(32'h1000_0003, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (imemAddr !== 32'h210) begin errors++; $display("[TB] FAIL beqbne_taken got %h want 210", imemAddr); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] heldPc;
        fetch(32'h0000_0020, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (imemAddr !== mPc) begin errors++; $display("[TB] FAIL b2b_advance got %h want %h", imemAddr, mPc); end
        heldPc = mPc;
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
        checks++; if (pc !== heldPc) begin errors++; $display("[TB] FAIL b2b_reqadv got %h want %h", pc, heldPc); end
        fetch(32'h2109_0001, 0);
        imemAck = 1'b1; imemData = 32'hFFFF_FFFF;
        @(negedge clk);
        imemAck = 1'b0;
        checks++; if (instr !== 32'h2109_0001) begin errors++; $display("[TB] FAIL b2b_strayack got %h want 21090001", instr); end
        checks++; if (instrValid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_strayvalid got %b want 0", instrValid); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (imemAddr !== mPc) begin errors++; $display("[TB] FAIL b2b_addr got %h want %h", imemAddr, mPc); end
    endtask

    task automatic test_wrap_backpressure();
        fetch(32'h0800_0000, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        fetch(32'h1000_FFFE, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (imemAddr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_reach got %h want fffffffc", imemAddr); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (imemAddr !== 32'hFFFF_FFFC || imemReq !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold addr %h req %b want fffffffc 1", imemAddr, imemReq); end
            @(negedge clk);
        end
        mStall += 5;
        imemAck = 1'b1; imemData = 32'h0000_0000;
        @(negedge clk);
        imemAck = 1'b0;
        mInstr = 32'h0;
        checks++; if (stallCycles !== expStall()) begin errors++; $display("[TB] FAIL bp_stall got %0d want %0d", stallCycles, expStall()); end
        checks++; if (pcPlus4 !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc4 got %h want 0", pcPlus4); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (imemAddr !== 32'h0) begin errors++; $display("[TB] FAIL wrap_next got %h want 0", imemAddr); end
    endtask

    task automatic test_jump_priority();
        fetch(32'h1000_FFFD, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (imemAddr !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL jp_reach got %h want fffffff8", imemAddr); end
        fetch(32'h0800_0010, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checks++; if (imemAddr !== 32'hF000_0040) begin errors++; $display("[TB] FAIL jp_target got %h want f0000040", imemAddr); end
    endtask

    task automatic test_random();
        logic [31:0] word;
        int          delay;
        int          hold;
        for (int it = 0; it < 40; it++) begin
            word  = $urandom;
            delay = $urandom_range(0, 3);
            waitReq();
            for (int d = 0; d < delay; d++) begin
                advance = 1'($urandom);
                @(negedge clk);
                advance = 1'b0;
            end
            mStall += delay;
            imemAck = 1'b1; imemData = word;
            @(negedge clk);
            imemAck = 1'b0;
            mInstr = word;
            checks++; if (instrValid !== 1'b1 || instr !== mInstr || opcode !== mInstr[31:26]) begin errors++; $display("[TB] FAIL rnd_load instr %h op %h v %b want %h", instr, opcode, instrValid, mInstr); end
            checks++; if (pc !== mPc || pcPlus4 !== mPc + 32'd4) begin errors++; $display("[TB] FAIL rnd_pc got %h/%h want %h", pc, pcPlus4, mPc); end
            checks++; if (stallCycles !== expStall()) begin errors++; $display("[TB] FAIL rnd_stall got %0d want %0d", stallCycles, expStall()); end
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                imemAck = 1'($urandom); imemData = $urandom;
                @(negedge clk);
            end
            imemAck = 1'b0;
            checks++; if (instr !== mInstr) begin errors++; $display("[TB] FAIL rnd_hold got %h want %h", instr, mInstr); end
            applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
            checks++; if (imemReq !== 1'b1 || imemAddr !== mPc) begin errors++; $display("[TB] FAIL rnd_next req %b addr %h want 1 %h", imemReq, imemAddr, mPc); end
        end
    endtask

    task automatic test_reset_mid_fetch();
        waitReq();
        #2 rstN = 1'b0;
        #1;
        checks++; if (imemReq !== 1'b0) begin errors++; $display("[TB] FAIL mid_req got %b want 0", imemReq); end
        checks++; if (imemAddr !== RST_PC) begin errors++; $display("[TB] FAIL mid_addr got %h want %h", imemAddr, RST_PC); end
        checks++; if (stallCycles !== '0) begin errors++; $display("[TB] FAIL mid_stall got %0d want 0", stallCycles); end
        @(negedge clk);
        rstN = 1'b1;
        imemAck = 1'b1; imemData = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (instr !== 32'h0 || instrValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_strayack instr %h v %b want 0 0", instr, instrValid); end
        checks++; if (imemReq !== 1'b1) begin errors++; $display("[TB] FAIL mid_rereq got %b want 1", imemReq); end
        imemAck = 1'b0;
        mPc = RST_PC; mStall = 0;
        fetch(32'h2008_0005, 0);
        checks++; if (instr !== 32'h2008_0005 || pc !== RST_PC) begin errors++; $display("[TB] FAIL mid_refetch instr %h pc %h want 20080005 %h", instr, pc, RST_PC); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_back_to_back();
        test_wrap_backpressure();
        test_jump_priority();
        test_random();
        test_reset_mid_fetch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
